// File: rtl/display_scan_controller.sv
// -----------------------------------------------------------------------------
// display_scan_controller
//
// Drives a 4-digit common-anode 7-segment display from one fast clock. Each
// digit gets a slot of TICK_DIV clock cycles. The first BLANK_CYCLES cycles of
// the slot keep every anode off so the previous digit's segments cannot ghost
// into the next one. The remaining cycles light the digit.
//
// The displayed value, decimal points and digit mask are captured once per
// frame, on entry to the blank phase of digit 0. A frame is therefore always
// drawn from one consistent value.
//
// Parameters
//   TICK_DIV      clock cycles per digit slot (blank + show)
//   BLANK_CYCLES  dark cycles at the start of each slot, 1 <= BLANK_CYCLES < TICK_DIV
//
// Ports
//   reloj       in   system clock
//   reset       in   asynchronous reset, active-high
//   enable      in   1 = scan running, 0 = display dark
//   valor       in   4 hex digits, digit i = valor[4i+3:4i]
//   punto       in   decimal point per digit, 1 = lit
//   mascara     in   digit enable per digit, 1 = digit may light
//   anodos      out  anode drive, active-low, bit i = digit i
//   segmentos   out  segment drive, active-low, {g,f,e,d,c,b,a}
//   dp          out  decimal point drive, active-low
//   fin_cuadro  out  1-cycle pulse in the first blank cycle after digit 3
//
// Optional feature (compile-time macro LEADING_ZERO_BLANK_EN)
//   When defined, leading zero digits (from digit 3 downward, up to the first
//   non-zero digit) are darkened. Digit 0 is never suppressed. A suppressed
//   digit's decimal point still follows punto.
// -----------------------------------------------------------------------------
module display_scan_controller #(
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        reloj,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] valor,
  input  logic [3:0]  punto,
  input  logic [3:0]  mascara,
  output logic [3:0]  anodos,
  output logic [6:0]  segmentos,
  output logic        dp,
  output logic        fin_cuadro
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST       = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t          state, state_nx;
  logic [1:0]      idx, idx_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            latch_en;

  logic [15:0]     valor_l;
  logic [3:0]      punto_l;
  logic [3:0]      mascara_l;
  logic [3:0]      sup_l;

  logic [3:0]      anodos_nx;
  logic [6:0]      segmentos_nx;
  logic            dp_nx;
  logic            fin_nx;
  logic            lit;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is suppressed when it and every digit above it are zero.
  function automatic logic [3:0] lead_zero_mask(input logic [15:0] v);
    logic [3:0] m;
    m[3] = (v[15:12] == 4'h0);
    m[2] = m[3] && (v[11:8] == 4'h0);
    m[1] = m[2] && (v[7:4] == 4'h0);
    m[0] = 1'b0;
    return m;
  endfunction
`endif

  // Next-state logic. enable=0 overrides every state so the display goes dark
  // on the next edge wherever the scan was.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt + 1'b1;
    latch_en = 1'b0;
    fin_nx   = 1'b0;

    if (!enable) begin
      state_nx = IDLE;
      idx_nx   = 2'd0;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = BLANK;
          idx_nx   = 2'd0;
          cnt_nx   = '0;
          latch_en = 1'b1;
        end
        BLANK: begin
          if (cnt == CNT_BLANK_LAST) state_nx = SHOW;
        end
        SHOW: begin
          if (cnt == CNT_LAST) begin
            state_nx = BLANK;
            cnt_nx   = '0;
            idx_nx   = idx + 2'd1;
            if (idx == 2'd3) begin
              latch_en = 1'b1;
              fin_nx   = 1'b1;
            end
          end
        end
        default: begin
          state_nx = IDLE;
          idx_nx   = 2'd0;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Output decode, computed from the next state so the pins are registered
  // and still line up with the state they belong to. The latched value is
  // stable before any SHOW phase begins, so the registered copy is used.
  always_comb begin
    anodos_nx    = 4'hF;
    segmentos_nx = 7'h7F;
    dp_nx        = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    lit          = mascara_l[idx_nx] && !sup_l[idx_nx];
`else
    lit          = mascara_l[idx_nx];
`endif
    if (state_nx == SHOW) begin
      if (lit) begin
        anodos_nx    = ~(4'b0001 << idx_nx);
        segmentos_nx = hex_decode(valor_l[{idx_nx, 2'b00} +: 4]);
      end
      dp_nx = ~(punto_l[idx_nx] && mascara_l[idx_nx]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 2'd0;
      cnt        <= '0;
      anodos     <= 4'hF;
      segmentos  <= 7'h7F;
      dp         <= 1'b1;
      fin_cuadro <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      cnt        <= cnt_nx;
      anodos     <= anodos_nx;
      segmentos  <= segmentos_nx;
      dp         <= dp_nx;
      fin_cuadro <= fin_nx;
    end
  end

  // Frame latch: the image shown for a whole frame comes from one sample.
  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      valor_l   <= '0;
      punto_l   <= '0;
      mascara_l <= '0;
      sup_l     <= '0;
    end else if (latch_en) begin
      valor_l   <= valor;
      punto_l   <= punto;
      mascara_l <= mascara;
`ifdef LEADING_ZERO_BLANK_EN
      sup_l     <= lead_zero_mask(valor);
`else
      sup_l     <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_display_scan_controller
//
// Directed bench for display_scan_controller with TICK_DIV=10, BLANK_CYCLES=2.
// The stimulus process queues the expected pin state {anodos, segmentos, dp,
// fin_cuadro} for every upcoming clock cycle. A monitor process pops one entry
// per falling edge and compares it with the DUT pins.
// -----------------------------------------------------------------------------
module tb_display_scan_controller;

  localparam int TD = 10;
  localparam int BC = 2;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] valor;
  logic [3:0]  punto;
  logic [3:0]  mascara;
  logic [3:0]  anodos;
  logic [6:0]  segmentos;
  logic        dp;
  logic        fin_cuadro;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fin;
  } rec_t;

  rec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  display_scan_controller #(.TICK_DIV(TD), .BLANK_CYCLES(BC)) dut (
    .reloj      (clk),
    .reset      (reset),
    .enable     (enable),
    .valor      (valor),
    .punto      (punto),
    .mascara    (mascara),
    .anodos     (anodos),
    .segmentos  (segmentos),
    .dp         (dp),
    .fin_cuadro (fin_cuadro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got {an,seg,dp,fin}=%h required %h", name, act, exp_v);
    end
  endtask

  // Monitor: one comparison per cycle while expectations are queued.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      rec_t e;
      e = exp_q.pop_front();
      check($sformatf("pins@%0t", $time), {anodos, segmentos, dp, fin_cuadro}, e);
    end
  end

  function automatic rec_t dark_rec(input logic fin);
    rec_t r;
    r.an  = 4'hF;
    r.seg = 7'h7F;
    r.dp  = 1'b1;
    r.fin = fin;
    return r;
  endfunction

  task automatic push_dark(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(dark_rec(1'b0));
  endtask

  // Queue the first 'count' cycles of one frame drawn from v/m/p.
  task automatic push_frame(input logic [15:0] v, input logic [3:0] m,
                            input logic [3:0] p, input logic fin, input int count);
    logic [3:0] sup;
    sup = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
    sup[3] = (v[15:12] == 4'h0);
    sup[2] = sup[3] && (v[11:8] == 4'h0);
    sup[1] = sup[2] && (v[7:4] == 4'h0);
`endif
    for (int i = 0; i < count; i++) begin
      rec_t r;
      int   s;
      int   ph;
      s  = i / TD;
      ph = i % TD;
      r  = dark_rec((i == 0) && fin);
      if (ph >= BC) begin
        if (m[s] && !sup[s]) begin
          r.an    = 4'hF;
          r.an[s] = 1'b0;
          r.seg   = seg_tab[v[s*4 +: 4]];
        end
        r.dp = ~(p[s] & m[s]);
      end
      exp_q.push_back(r);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns just after the rising edge that follows the last queued cycle.
  task automatic wait_drain();
    int budget;
    budget = 500;
    do begin
      @(posedge clk);
      #1;
      budget--;
    end while (exp_q.size() > 0 && budget > 0);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d expectations left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    valor   = 16'h1234;
    mascara = 4'hF;
    punto   = 4'h0;
    @(posedge clk);
    #1;

    // Reset and idle: dark.
    push_dark(3);
    wait_drain();
    reset = 1'b0;
    push_dark(2);
    wait_drain();

    // Basic scan of 1234: one idle cycle, then frames back to back.
    enable = 1'b1;
    push_dark(1);
    push_frame(16'h1234, 4'hF, 4'h0, 1'b0, 40);
    push_frame(16'h1234, 4'hF, 4'h0, 1'b1, 40);
    wait_drain();

    // Mid-frame value change, then mask/decimal point change.
    push_frame(16'h1234, 4'hF, 4'h0, 1'b1, 40);
    push_frame(16'hABCD, 4'hF, 4'h0, 1'b1, 40);
    push_frame(16'hABCD, 4'b0101, 4'b0001, 1'b1, 40);
    wait_cycles(15);
    valor = 16'hABCD;
    wait_cycles(40);
    mascara = 4'b0101;
    punto   = 4'b0001;
    wait_cycles(40);
    mascara = 4'hF;
    punto   = 4'h0;
    valor   = 16'h1234;
    push_frame(16'h1234, 4'hF, 4'h0, 1'b1, 15);
    wait_drain();

    // Asynchronous reset in the middle of digit 1's show phase.
    push_dark(3);
    #3;
    reset = 1'b1;
    wait_drain();
    reset = 1'b0;
    push_dark(1);
    push_frame(16'h1234, 4'hF, 4'h0, 1'b0, 40);
    push_frame(16'h1234, 4'hF, 4'h0, 1'b1, 25);
    wait_drain();

    // One-cycle enable drop during digit 2, then restart with a new value.
    exp_q.push_back('{an: 4'b1011, seg: 7'h24, dp: 1'b1, fin: 1'b0});
    push_dark(1);
    enable = 1'b0;
    wait_cycles(1);
    enable = 1'b1;
    valor  = 16'h0005;
    push_frame(16'h0005, 4'hF, 4'h0, 1'b0, 40);
    push_frame(16'h0005, 4'hF, 4'h0, 1'b1, 40);
    wait_drain();

    // Disable at a frame boundary: pulse still seen, then dark.
    push_frame(16'h0005, 4'hF, 4'h0, 1'b1, 1);
    push_dark(3);
    enable = 1'b0;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
